// File: rtl/board_dump.sv
// Reads a 64-square board snapshot and streams it as one ASCII byte per square over valid/ready.
// Optional build macro BOARD_DUMP_ROW_DELIM_EN appends an LF byte after every row (72 bytes per dump).
module board_dump #(
  parameter bit         FLIP       = 1'b0,
  parameter logic [7:0] EMPTY_CHAR = 8'h2E,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [255:0] BOARD,
  input  logic         START,
  output logic [7:0]   TX_DATA,
  output logic         TX_VALID,
  input  logic         TX_READY,
  output logic         BUSY,
  output logic         DONE
);

`ifdef BOARD_DUMP_ROW_DELIM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN, DELIM} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

  localparam logic [2:0] FIRST_ROW = FLIP ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST_ROW  = FLIP ? 3'd7 : 3'd0;

  state_t         state;
  state_t         state_nxt;
  logic [255:0]   snap;
  logic [2:0]     row;
  logic [2:0]     col;
  logic           xfer;
  logic           last_col;
  logic           last_row;
  logic [7:0]     sq_idx;
  logic [2:0]     row_step;

  function automatic logic [7:0] to_ascii(input logic [3:0] code);
    logic [7:0] ch;
    case (code[2:0])
      3'd1:    ch = 8'h50;
      3'd2:    ch = 8'h4E;
      3'd3:    ch = 8'h42;
      3'd4:    ch = 8'h52;
      3'd5:    ch = 8'h51;
      3'd6:    ch = 8'h4B;
      3'd0:    ch = EMPTY_CHAR;
      default: ch = BAD_CHAR;
    endcase
    // Colour bit only affects real pieces: black pieces are lower case.
    if (code[2:0] != 3'd0 && code[2:0] != 3'd7 && !code[3])
      ch = ch + 8'h20;
    return ch;
  endfunction

  assign xfer     = TX_VALID & TX_READY;
  assign last_col = (col == 3'd7);
  assign last_row = (row == LAST_ROW);
  assign sq_idx   = {row, col, 2'b00};
  assign row_step = FLIP ? 3'(row + 3'd1) : 3'(row - 3'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        if (xfer) begin
`ifdef BOARD_DUMP_ROW_DELIM_EN
          state_nxt = last_col ? DELIM : LOAD;
`else
          state_nxt = (last_col && last_row) ? FIN : LOAD;
`endif
        end
      end
`ifdef BOARD_DUMP_ROW_DELIM_EN
      DELIM: if (xfer) state_nxt = last_row ? FIN : LOAD;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      snap     <= '0;
      row      <= '0;
      col      <= '0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (START) begin
            snap <= BOARD;
            row  <= FIRST_ROW;
            col  <= 3'd0;
            BUSY <= 1'b1;
          end
        end
        LOAD: begin
          TX_DATA  <= to_ascii(snap[sq_idx +: 4]);
          TX_VALID <= 1'b1;
        end
        SEND: begin
          if (xfer) begin
            TX_VALID <= 1'b0;
            col      <= 3'(col + 3'd1);
`ifdef BOARD_DUMP_ROW_DELIM_EN
            // Row advance is deferred to the delimiter so its last-row test sees the current row.
            if (last_col) begin
              TX_DATA  <= 8'h0A;
              TX_VALID <= 1'b1;
            end
`else
            if (last_col) begin
              row <= row_step;
              if (last_row) begin
                BUSY <= 1'b0;
                DONE <= 1'b1;
              end
            end
`endif
          end
        end
`ifdef BOARD_DUMP_ROW_DELIM_EN
        DELIM: begin
          if (xfer) begin
            TX_VALID <= 1'b0;
            row      <= row_step;
            if (last_row) begin
              BUSY <= 1'b0;
              DONE <= 1'b1;
            end
          end
        end
`endif
        FIN:     DONE <= 1'b0;
        default: DONE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_dump.sv
// Directed bench for board_dump: initial-position dumps under varied sink readiness, snapshot,
// ignored START, and mid-dump reset. Follows BOARD_DUMP_ROW_DELIM_EN when defined (FLIP=1 then).
module tb_board_dump;

`ifdef BOARD_DUMP_ROW_DELIM_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [255:0] BOARD;
  logic         START = 1'b0;
  logic [7:0]   TX_DATA;
  logic         TX_VALID;
  logic         TX_READY = 1'b0;
  logic         BUSY;
  logic         DONE;

  int    checks = 0;
  int    errors = 0;
  string exp_s;
  int    nb;
  int    nd;

  board_dump #(.FLIP(FLIP), .EMPTY_CHAR(8'h2E), .BAD_CHAR(8'h3F)) dut (
    .CLK(CLK), .RESET(RESET), .BOARD(BOARD), .START(START),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic init_board();
    logic [2:0] back [8];
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    BOARD = '0;
    for (int c = 0; c < 8; c++) begin
      BOARD[4*c +: 4]        = {1'b1, back[c]};
      BOARD[4*(8+c) +: 4]    = 4'h9;
      BOARD[4*(48+c) +: 4]   = 4'h1;
      BOARD[4*(56+c) +: 4]   = {1'b0, back[c]};
    end
  endtask

  task automatic quiet(input string tag);
    int v;
    v = 0;
    repeat (10) begin
      @(negedge CLK);
      v += int'(TX_VALID) + int'(DONE) + int'(BUSY);
    end
    chk(tag, v, 0);
  endtask

  // One dump; duty is the percent chance TX_READY is high in a cycle.
  task automatic dump(input int duty, input bit mod_board, input bit extra_start,
                      input int reset_at, output int nbytes, output int ndone);
    bit         stalled;
    bit         fin;
    logic [7:0] held;
    nbytes = 0; ndone = 0; stalled = 0; fin = 0; held = '0;
    @(negedge CLK);
    START = 1'b1;
    TX_READY = ($urandom_range(99) < duty);
    @(negedge CLK);
    START = 1'b0;
    if (mod_board) BOARD[243:240] = 4'h0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      START = 1'b0;
      if (stalled) begin
        chk("stall_valid", TX_VALID, 1);
        chk("stall_data", TX_DATA, held);
      end
      TX_READY = ($urandom_range(99) < duty);
      if (DONE) begin
        ndone++;
        fin = 1;
        if (extra_start) START = 1'b1;
      end
      if (extra_start && TX_VALID && TX_READY && nbytes == 10) START = 1'b1;
      if (reset_at >= 0 && nbytes == reset_at && TX_VALID && !fin) begin
        RESET = 1'b1;
        #1;
        chk("rst_valid", TX_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_data", TX_DATA, 0);
        @(negedge CLK);
        chk("rst_done", DONE, 0);
        RESET = 1'b0;
        fin = 1;
        stalled = 0;
      end else if (TX_VALID && TX_READY && !fin) begin
        chk($sformatf("byte%0d", nbytes), TX_DATA, exp_s[nbytes]);
        nbytes++;
      end
      stalled = TX_VALID && !TX_READY && !fin;
      held = TX_DATA;
      if (!fin) @(negedge CLK);
    end
    if (!fin) chk("timeout", 1, 0);
    @(negedge CLK);
    START = 1'b0;
    TX_READY = 1'b0;
  endtask

  initial begin
`ifdef BOARD_DUMP_ROW_DELIM_EN
    exp_s = {"RNBQKBNR\n", "PPPPPPPP\n", "........\n", "........\n",
             "........\n", "........\n", "pppppppp\n", "rnbqkbnr\n"};
`else
    exp_s = {"rnbqkbnr", "pppppppp", "................................",
             "PPPPPPPP", "RNBQKBNR"};
`endif
    init_board();
    repeat (3) @(negedge CLK);
    chk("reset_data", TX_DATA, 0);
    chk("reset_valid", TX_VALID, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Full-rate sink
    dump(100, 0, 0, -1, nb, nd);
    chk("t1_count", nb, exp_s.len());
    chk("t1_done", nd, 1);
    quiet("t1_quiet");

    // Sporadic sink
    dump(30, 0, 0, -1, nb, nd);
    chk("t2_count", nb, exp_s.len());
    chk("t2_done", nd, 1);
    quiet("t2_quiet");

    // Board edited after START: snapshot must still hold the king
    dump(60, 1, 0, -1, nb, nd);
    chk("t3_count", nb, exp_s.len());
    chk("t3_done", nd, 1);
    init_board();
    quiet("t3_quiet");

    // START while busy and during the FIN cycle are ignored
    dump(60, 0, 1, -1, nb, nd);
    chk("t4_count", nb, exp_s.len());
    chk("t4_done", nd, 1);
    quiet("t4_quiet");

    // Reset mid-dump, then a fresh dump from the first square
    dump(100, 0, 0, 20, nb, nd);
    chk("t5_partial", nb, 20);
    chk("t5_nodone", nd, 0);
    quiet("t5_quiet");
    dump(100, 0, 0, -1, nb, nd);
    chk("t5_count", nb, exp_s.len());
    chk("t5_done", nd, 1);
    quiet("t5_quiet2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
